// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port among N_REQ
// requesters. Exactly one transaction is in flight at a time. The winner's
// op, address and store data are latched at grant, so requesters may change
// their signals freely once accepted.
//
// Handshake: a requester is eligible while avail is high together with r_en
// or w_en. The arbiter samples eligibility only in IDLE. On the memory side
// the strobe (mem_r_en or mem_w_en) stays high with stable address and data
// until mem_done is seen. The requester then gets a one-cycle req_done pulse
// with req_data_load valid, and must drop avail on that edge.
module mem_port_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic [N_REQ-1:0]          req_avail,
  input  logic [N_REQ-1:0]          req_r_en,
  input  logic [N_REQ-1:0]          req_w_en,
  input  logic [N_REQ*ADDR_W-1:0]   req_ptr,
  input  logic [N_REQ*DATA_W-1:0]   req_data_store,
  output logic [DATA_W-1:0]         req_data_load,
  output logic [N_REQ-1:0]          req_done,
  output logic                      mem_r_en,
  output logic                      mem_w_en,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_done,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id
);

  localparam int GW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [GW-1:0]     last_grant;
  logic [N_REQ-1:0]  eligible;
  logic              found;
  logic [GW-1:0]     winner;
  logic [GW-1:0]     cand;
  int                idx_v;
  logic [ADDR_W-1:0] sel_ptr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_w;

  // Avail without any enable is not a request.
  assign eligible = req_avail & (req_r_en | req_w_en);

  // Round-robin search starting just after the last winner, wrapping.
  always_comb begin
    found = 1'b0;
    winner = '0;
    cand = '0;
    idx_v = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx_v = (int'(last_grant) + off) % N_REQ;
      cand = GW'(idx_v);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        winner = cand;
      end
    end
  end

  // Mux the winner's request fields; write takes precedence over read.
  always_comb begin
    sel_ptr = '0;
    sel_data = '0;
    sel_w = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (GW'(i) == winner) begin
        sel_ptr = req_ptr[i*ADDR_W +: ADDR_W];
        sel_data = req_data_store[i*DATA_W +: DATA_W];
        sel_w = req_w_en[i];
      end
    end
  end

  // Control FSM with registered memory strobes, done pulse and read data.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state <= IDLE;
      last_grant <= GW'(N_REQ - 1);
      mem_r_en <= 1'b0;
      mem_w_en <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      req_done <= '0;
      req_data_load <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_done <= '0;
          if (found) begin
            last_grant <= winner;
            mem_w_en <= sel_w;
            mem_r_en <= !sel_w;
            mem_addr <= sel_ptr;
            mem_wdata <= sel_data;
            state <= BUSY;
          end
        end
        BUSY: begin
          // No timeout: the memory controller always completes eventually.
          if (mem_done) begin
            mem_r_en <= 1'b0;
            mem_w_en <= 1'b0;
            if (mem_r_en) req_data_load <= mem_rdata;
            req_done <= {{(N_REQ-1){1'b0}}, 1'b1} << last_grant;
            state <= RESP;
          end
        end
        RESP: begin
          req_done <= '0;
          state <= IDLE;
        end
        default: begin
          req_done <= '0;
          mem_r_en <= 1'b0;
          mem_w_en <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign grant_id = last_grant;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transactions, hand-written
// multi-cycle sequences, then randomized traffic against a round-robin model.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int GW = 2;
  localparam int EW = 3 + 1 + AW + DW;

  logic            clk = 1'b0;
  logic            rst_l;
  logic [N-1:0]    req_avail, req_r_en, req_w_en;
  logic [N*AW-1:0] req_ptr;
  logic [N*DW-1:0] req_data_store;
  logic [DW-1:0]   req_data_load;
  logic [N-1:0]    req_done;
  logic            mem_r_en, mem_w_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_done;
  logic            busy;
  logic [GW-1:0]   grant_id;

  mem_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_l(rst_l),
    .req_avail(req_avail), .req_r_en(req_r_en), .req_w_en(req_w_en),
    .req_ptr(req_ptr), .req_data_store(req_data_store),
    .req_data_load(req_data_load), .req_done(req_done),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .busy(busy), .grant_id(grant_id)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Requester driver state
  logic        a_av[N];
  logic        a_r[N];
  logic        a_w[N];
  logic [31:0] a_ptr[N];
  logic [31:0] a_dat[N];

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_avail[i] = a_av[i];
      req_r_en[i] = a_r[i];
      req_w_en[i] = a_w[i];
      req_ptr[i*AW +: AW] = a_ptr[i];
      req_data_store[i*DW +: DW] = a_dat[i];
    end
  endtask

  task automatic set_req(input int i, input bit r, input bit w, input logic [31:0] p, input logic [31:0] d);
    a_av[i] = 1'b1; a_r[i] = r; a_w[i] = w; a_ptr[i] = p; a_dat[i] = d;
    apply();
  endtask

  task automatic clr_req(input int i);
    a_av[i] = 1'b0; a_r[i] = 1'b0; a_w[i] = 1'b0;
    apply();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      a_av[i] = 0; a_r[i] = 0; a_w[i] = 0; a_ptr[i] = '0; a_dat[i] = '0;
    end
    apply();
    rst_l = 1'b0;
    tick();
    tick();
    rst_l = 1'b1;
  endtask

  // Memory responder: mem_done in the mem_k-th cycle the strobe is high
  int          resp_cnt = 0;
  int          mem_k = 1;
  bit          rand_k = 0;
  bit          spur = 0;
  logic [31:0] mem_rval = '0;
  logic [31:0] last_rval = '0;

  initial begin
    mem_done = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_r_en || mem_w_en) begin
        resp_cnt++;
        if (resp_cnt == mem_k) begin
          mem_done = 1'b1;
          mem_rdata = mem_rval;
          last_rval = mem_rval;
        end else begin
          mem_done = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        resp_cnt = 0;
        mem_done = spur;
        mem_rdata = spur ? 32'h5555AAAA : 32'h0;
        if (rand_k) begin
          mem_k = $urandom_range(1, 4);
          mem_rval = $urandom;
        end
      end
    end
  end

  // Table vectors
  typedef struct {
    int          idx;
    bit          r;
    bit          w;
    logic [31:0] ptr;
    logic [31:0] data;
    int          k;
    logic [31:0] rval;
    bit          exp_w;
    logic [31:0] exp_load;
  } vec_t;

  vec_t vt[5];

  // Random-phase scoreboard and model
  logic [EW-1:0] exp_q[$];
  bit            pend[N];
  int            op[N];
  int            mlast;
  logic [31:0]   model_load;
  bit            strobe_seen;

  task automatic rand_step(input bit gen);
    logic [EW-1:0] e;
    int idx;
    bit w;
    int best;
    tick();
    if (req_done !== '0) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rnd_done_unexpected: got req_done=%b expected none", req_done);
      end else begin
        e = exp_q.pop_front();
        idx = int'(e[EW-1 -: 3]);
        w = e[AW+DW];
        check("rnd_done", 64'(req_done), 64'(1) << idx);
        if (!w) model_load = last_rval;
        check("rnd_load", 64'(req_data_load), 64'(model_load));
        pend[idx] = 0; a_av[idx] = 0; a_r[idx] = 0; a_w[idx] = 0;
        strobe_seen = 0;
      end
    end
    if ((mem_r_en || mem_w_en) && !strobe_seen) begin
      strobe_seen = 1;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rnd_strobe_unexpected: got strobe with grant_id=%0d expected none", grant_id);
      end else begin
        e = exp_q[0];
        w = e[AW+DW];
        check("rnd_grant", 64'(grant_id), 64'(e[EW-1 -: 3]));
        check("rnd_w_en", 64'(mem_w_en), 64'(w));
        check("rnd_r_en", 64'(mem_r_en), 64'(!w));
        check("rnd_addr", 64'(mem_addr), 64'(e[AW+DW-1 -: AW]));
        if (w) check("rnd_wdata", 64'(mem_wdata), 64'(e[DW-1:0]));
      end
    end
    for (int i = 0; i < N; i++) begin
      if (pend[i] && op[i] == 4) begin
        pend[i] = 0; a_av[i] = 0;
      end else if (!pend[i] && gen && $urandom_range(0, 3) == 0) begin
        pend[i] = 1;
        op[i] = $urandom_range(1, 4);
        a_av[i] = 1;
        a_r[i] = (op[i] == 1 || op[i] == 3);
        a_w[i] = (op[i] == 2 || op[i] == 3);
        a_ptr[i] = $urandom;
        a_dat[i] = $urandom;
      end
    end
    // Changing the in-flight requester's fields must not matter.
    if (busy && exp_q.size() > 0 && $urandom_range(0, 1) == 1) begin
      idx = int'(exp_q[0][EW-1 -: 3]);
      a_ptr[idx] = $urandom;
      a_dat[idx] = $urandom;
    end
    apply();
    if (!busy) begin
      best = -1;
      for (int o = 1; o <= N; o++) begin
        int c;
        c = (mlast + o) % N;
        if (best < 0 && pend[c] && op[c] != 4) best = c;
      end
      if (best >= 0) begin
        w = (op[best] != 1);
        exp_q.push_back({3'(best), w, a_ptr[best], a_dat[best]});
        mlast = best;
      end
    end
  endtask

  initial begin
    int n;
    int seq[$];
    int dcyc[$];
    int cyc;
    logic [31:0] exp_load;

    vt[0] = '{2, 1'b1, 1'b0, 32'h40, 32'h0,        3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    vt[1] = '{1, 1'b0, 1'b1, 32'h10, 32'h3F800000, 1, 32'h11111111, 1'b1, 32'hDEADBEEF};
    vt[2] = '{0, 1'b1, 1'b1, 32'h20, 32'h12345678, 2, 32'hFFFF0000, 1'b1, 32'hDEADBEEF};
    vt[3] = '{3, 1'b1, 1'b0, 32'h80, 32'h0,        1, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D};
    vt[4] = '{0, 1'b1, 1'b0, 32'h04, 32'h0,        4, 32'h0BADC0DE, 1'b0, 32'h0BADC0DE};

    for (int i = 0; i < N; i++) begin
      a_av[i] = 0; a_r[i] = 0; a_w[i] = 0; a_ptr[i] = '0; a_dat[i] = '0;
      pend[i] = 0; op[i] = 0;
    end
    apply();
    rst_l = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_r_en", 64'(mem_r_en), 64'(0));
    check("rst_w_en", 64'(mem_w_en), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_wdata", 64'(mem_wdata), 64'(0));
    check("rst_done", 64'(req_done), 64'(0));
    check("rst_load", 64'(req_data_load), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_grant", 64'(grant_id), 64'(N - 1));
    rst_l = 1'b1;
    tick();

    // Table-driven single transactions
    for (int v = 0; v < 5; v++) begin
      mem_k = vt[v].k;
      mem_rval = vt[v].rval;
      set_req(vt[v].idx, vt[v].r, vt[v].w, vt[v].ptr, vt[v].data);
      tick();
      check("tbl_busy", 64'(busy), 64'(1));
      check("tbl_grant", 64'(grant_id), 64'(vt[v].idx));
      check("tbl_w_en", 64'(mem_w_en), 64'(vt[v].exp_w));
      check("tbl_r_en", 64'(mem_r_en), 64'(!vt[v].exp_w));
      check("tbl_addr", 64'(mem_addr), 64'(vt[v].ptr));
      if (vt[v].exp_w) check("tbl_wdata", 64'(mem_wdata), 64'(vt[v].data));
      a_ptr[vt[v].idx] = ~vt[v].ptr;
      a_dat[vt[v].idx] = ~vt[v].data;
      apply();
      n = 1;
      while (req_done === '0 && n < 20) begin
        tick();
        n++;
        if (req_done === '0) check("tbl_addr_hold", 64'(mem_addr), 64'(vt[v].ptr));
      end
      check("tbl_latency", 64'(n), 64'(vt[v].k + 1));
      check("tbl_done", 64'(req_done), 64'(1) << vt[v].idx);
      check("tbl_load", 64'(req_data_load), 64'(vt[v].exp_load));
      check("tbl_strobe_off", 64'(mem_r_en | mem_w_en), 64'(0));
      clr_req(vt[v].idx);
      tick();
      check("tbl_done_once", 64'(req_done), 64'(0));
    end

    // All four eligible at once after reset: grants 0,1,2,3 at 3-cycle spacing
    do_reset();
    mem_k = 1;
    mem_rval = 32'hA5A50001;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 32'(i * 16), 32'h0);
    seq.delete(); dcyc.delete();
    cyc = 0;
    while (seq.size() < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (req_done !== '0) begin
        check("all4_onehot", 64'($onehot(req_done)), 64'(1));
        for (int i = 0; i < N; i++) if (req_done[i]) begin seq.push_back(i); dcyc.push_back(cyc); clr_req(i); end
      end
    end
    check("all4_count", 64'(seq.size()), 64'(4));
    for (int j = 0; j < seq.size(); j++) begin
      check("all4_order", 64'(seq[j]), 64'(j));
      check("all4_cycle", 64'(dcyc[j]), 64'(3 * j + 2));
    end
    repeat (3) tick();
    check("all4_no_extra", 64'(req_done), 64'(0));

    // Fairness: req 0 and req 3 both stay eligible; expect strict alternation
    mem_rval = 32'hB0B00002;
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h0);
    set_req(3, 1'b1, 1'b0, 32'h300, 32'h0);
    seq.delete();
    cyc = 0;
    while (seq.size() < 6 && cyc < 60) begin
      tick();
      cyc++;
      if (req_done !== '0) begin
        check("fair_onehot", 64'($onehot(req_done)), 64'(1));
        for (int i = 0; i < N; i++) if (req_done[i]) seq.push_back(i);
      end
    end
    check("fair_count", 64'(seq.size()), 64'(6));
    for (int j = 0; j < seq.size(); j++) check("fair_order", 64'(seq[j]), 64'((j % 2 == 0) ? 0 : 3));
    clr_req(0);
    clr_req(3);
    repeat (2) tick();

    // Avail without enable is never granted; stray mem_done in IDLE is ignored
    exp_load = 32'hB0B00002;
    a_av[1] = 1'b1;
    apply();
    spur = 1;
    tick();
    spur = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("noen_busy", 64'(busy), 64'(0));
      check("noen_done", 64'(req_done), 64'(0));
      check("noen_strobe", 64'(mem_r_en | mem_w_en), 64'(0));
    end
    check("noen_load", 64'(req_data_load), 64'(exp_load));
    check("noen_grant", 64'(grant_id), 64'(3));
    clr_req(1);

    // Reset while BUSY abandons the op; next grant goes to lowest eligible index
    mem_k = 10;
    set_req(0, 1'b1, 1'b0, 32'h500, 32'h0);
    tick();
    check("rbusy_strobe", 64'(mem_r_en), 64'(1));
    rst_l = 1'b0;
    tick();
    check("rbusy_r_en", 64'(mem_r_en), 64'(0));
    check("rbusy_w_en", 64'(mem_w_en), 64'(0));
    check("rbusy_addr", 64'(mem_addr), 64'(0));
    check("rbusy_done", 64'(req_done), 64'(0));
    check("rbusy_load", 64'(req_data_load), 64'(0));
    check("rbusy_busy", 64'(busy), 64'(0));
    check("rbusy_grant", 64'(grant_id), 64'(3));
    rst_l = 1'b1;
    clr_req(0);
    mem_k = 1;
    mem_rval = 32'h22223333;
    set_req(2, 1'b1, 1'b0, 32'h200, 32'h0);
    set_req(3, 1'b1, 1'b0, 32'h300, 32'h0);
    tick();
    check("rbusy_next_grant", 64'(grant_id), 64'(2));
    check("rbusy_next_addr", 64'(mem_addr), 64'(32'h200));
    n = 0;
    do begin tick(); n++; end while (req_done === '0 && n < 10);
    check("rbusy_next_done", 64'(req_done), 64'(4'b0100));
    check("rbusy_next_load", 64'(req_data_load), 64'(32'h22223333));
    clr_req(2);
    n = 0;
    do begin tick(); n++; end while (req_done === '0 && n < 10);
    check("rbusy_then3_done", 64'(req_done), 64'(4'b1000));
    clr_req(3);
    tick();

    // Randomized traffic against the round-robin model
    do_reset();
    mlast = N - 1;
    model_load = '0;
    strobe_seen = 0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin pend[i] = 0; op[i] = 0; end
    rand_k = 1;
    for (int c = 0; c < 3000; c++) rand_step(1'b1);
    for (int c = 0; c < 150; c++) rand_step(1'b0);
    check("rnd_drained", 64'(exp_q.size()), 64'(0));
    check("rnd_idle", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
